// File: rtl/iir_biquad_seq.sv
// iir_biquad_seq: second-order IIR section built on one shared multiplier.
// y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] + a1*y[n-1] + a2*y[n-2]
// Each sample takes 7 cycles: accept, five MAC taps, and one output cycle.
// Optional feature: define IIR_SAT_EN to saturate the output and add the sat_flag port.
module iir_biquad_seq #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned FRAC_W = 6,
  parameter int unsigned ACC_W  = DATA_W + COEF_W + 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] xn,
  input  logic signed [COEF_W-1:0] b0,
  input  logic signed [COEF_W-1:0] b1,
  input  logic signed [COEF_W-1:0] b2,
  input  logic signed [COEF_W-1:0] a1,
  input  logic signed [COEF_W-1:0] a2,
  output logic                     out_valid,
`ifdef IIR_SAT_EN
  output logic                     sat_flag,
`endif
  output logic signed [DATA_W-1:0] yn
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned TAP_W  = 3;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Coefficient set latched at acceptance
  typedef struct packed {
    logic signed [COEF_W-1:0] b0;
    logic signed [COEF_W-1:0] b1;
    logic signed [COEF_W-1:0] b2;
    logic signed [COEF_W-1:0] a1;
    logic signed [COEF_W-1:0] a2;
  } coef_t;

  state_e                    state_q, state_d;
  logic [TAP_W-1:0]          tap_q, tap_d;
  logic signed [DATA_W-1:0]  x_q, x_d;
  coef_t                     coef_q, coef_d;
  logic signed [DATA_W-1:0]  x1_q, x1_d;
  logic signed [DATA_W-1:0]  x2_q, x2_d;
  logic signed [DATA_W-1:0]  y1_q, y1_d;
  logic signed [DATA_W-1:0]  y2_q, y2_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0]  yn_q, yn_d;
  logic                      out_valid_q, out_valid_d;
`ifdef IIR_SAT_EN
  logic                      sat_flag_q, sat_flag_d;
`endif

  logic signed [DATA_W-1:0]  mul_a_c;
  logic signed [COEF_W-1:0]  mul_b_c;
  logic signed [PROD_W-1:0]  prod_c;
  logic signed [DATA_W-1:0]  y_fit_c;
`ifdef IIR_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = -Y_MAX - ACC_W'(1);
  logic signed [ACC_W-1:0]   r_c;
  logic                      clip_c;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign yn        = yn_q;
`ifdef IIR_SAT_EN
  assign sat_flag  = sat_flag_q;
`endif

  // Select the data/coefficient pair for the current tap
  always_comb begin
    mul_a_c = x_q;
    mul_b_c = coef_q.b0;
    case (tap_q)
      TAP_W'(0): begin mul_a_c = x_q;  mul_b_c = coef_q.b0; end
      TAP_W'(1): begin mul_a_c = x1_q; mul_b_c = coef_q.b1; end
      TAP_W'(2): begin mul_a_c = x2_q; mul_b_c = coef_q.b2; end
      TAP_W'(3): begin mul_a_c = y1_q; mul_b_c = coef_q.a1; end
      default:   begin mul_a_c = y2_q; mul_b_c = coef_q.a2; end
    endcase
  end

  // Shared full-precision signed multiplier
  assign prod_c = PROD_W'(mul_a_c) * PROD_W'(mul_b_c);

  // Scale accumulator back to sample units (floor) and fit to DATA_W
`ifdef IIR_SAT_EN
  always_comb begin
    r_c     = acc_q >>> FRAC_W;
    clip_c  = 1'b0;
    y_fit_c = DATA_W'(r_c);
    if (r_c > Y_MAX) begin
      y_fit_c = DATA_W'(Y_MAX);
      clip_c  = 1'b1;
    end else if (r_c < Y_MIN) begin
      y_fit_c = DATA_W'(Y_MIN);
      clip_c  = 1'b1;
    end
  end
`else
  always_comb begin
    y_fit_c = DATA_W'(acc_q >>> FRAC_W);
  end
`endif

  // Next-state and datapath update; clr overrides everything but yn
  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    x_d         = x_q;
    coef_d      = coef_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    acc_d       = acc_q;
    yn_d        = yn_q;
    out_valid_d = 1'b0;
`ifdef IIR_SAT_EN
    sat_flag_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d       = xn;
          coef_d.b0 = b0;
          coef_d.b1 = b1;
          coef_d.b2 = b2;
          coef_d.a1 = a1;
          coef_d.a2 = a2;
          acc_d     = '0;
          tap_d     = '0;
          state_d   = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod_c);
        if (tap_q == LAST_TAP) begin
          state_d = OUT;
        end else begin
          tap_d = tap_q + TAP_W'(1);
        end
      end
      OUT: begin
        yn_d        = y_fit_c;
        out_valid_d = 1'b1;
`ifdef IIR_SAT_EN
        sat_flag_d  = clip_c;
`endif
        x2_d        = x1_q;
        x1_d        = x_q;
        y2_d        = y1_q;
        y1_d        = y_fit_c;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clr) begin
      x1_d        = '0;
      x2_d        = '0;
      y1_d        = '0;
      y2_d        = '0;
      acc_d       = '0;
      tap_d       = '0;
      yn_d        = yn_q;
      out_valid_d = 1'b0;
`ifdef IIR_SAT_EN
      sat_flag_d  = 1'b0;
`endif
      state_d     = IDLE;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      x_q         <= '0;
      coef_q      <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      acc_q       <= '0;
      yn_q        <= '0;
      out_valid_q <= 1'b0;
`ifdef IIR_SAT_EN
      sat_flag_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      x_q         <= x_d;
      coef_q      <= coef_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      acc_q       <= acc_d;
      yn_q        <= yn_d;
      out_valid_q <= out_valid_d;
`ifdef IIR_SAT_EN
      sat_flag_q  <= sat_flag_d;
`endif
    end
  end

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Directed bench for iir_biquad_seq (DATA_W=8, COEF_W=8, FRAC_W=6).
// Define IIR_SAT_EN for both files to exercise the saturating build.
module tb_iir_biquad_seq;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] xn;
  logic signed [7:0] b0, b1, b2, a1, a2;
  logic              out_valid;
  logic signed [7:0] yn;
`ifdef IIR_SAT_EN
  logic              sat_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  iir_biquad_seq #(
    .DATA_W(8),
    .COEF_W(8),
    .FRAC_W(6),
    .ACC_W (19)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .xn       (xn),
    .b0       (b0),
    .b1       (b1),
    .b2       (b2),
    .a1       (a1),
    .a2       (a2),
    .out_valid(out_valid),
`ifdef IIR_SAT_EN
    .sat_flag (sat_flag),
`endif
    .yn       (yn)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle history flush
  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Push one sample, verify busy window, latency, result and strobe width
  task automatic send(input int x, input int c0, input int c1, input int c2,
                      input int c3, input int c4, input int exp_y,
                      input int exp_sat, input string tag);
    int waited;
    int busy_bad;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_ready_before"}, int'(in_ready), 1);
    xn = 8'(x); b0 = 8'(c0); b1 = 8'(c1); b2 = 8'(c2); a1 = 8'(c3); a2 = 8'(c4);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // Scramble inputs: they must not matter after acceptance
    xn = 8'(-x); b0 = 8'(7); b1 = 8'(-9); b2 = 8'(3);
    busy_bad = 0;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) tick();
      if (in_ready || out_valid) busy_bad++;
    end
    check({tag, "_busy"}, busy_bad, 0);
    tick();
    check({tag, "_out_valid"}, int'(out_valid), 1);
    check({tag, "_yn"}, int'(yn), exp_y);
    check({tag, "_ready_after"}, int'(in_ready), 1);
`ifdef IIR_SAT_EN
    check({tag, "_sat"}, int'(sat_flag), exp_sat);
`else
    if (exp_sat != 0) check({tag, "_sat_expect"}, exp_sat, 0);
`endif
    tick();
    check({tag, "_strobe_width"}, int'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_acc;
    int n_out;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
    xn = '0; b0 = '0; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
    tick();
    tick();
    check("rst_yn", int'(yn), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
`ifdef IIR_SAT_EN
    check("rst_sat", int'(sat_flag), 0);
`endif
    rst_n = 1'b1;
    tick();

    // Pass-through with latency/busy checks
    send(25, 64, 0, 0, 0, 0, 25, 0, "pass");

    // One-sample delay through b1, then floor rounding of -1.5
    pulse_clr();
    send(10, 0, 64, 0, 0, 0, 0, 0, "dly0");
    send(20, 0, 64, 0, 0, 0, 10, 0, "dly1");
    send(30, 0, 64, 0, 0, 0, 20, 0, "dly2");
    send(-3, 32, 0, 0, 0, 0, -2, 0, "floor");

    // First-order recursion y = x + 0.5*y1
    pulse_clr();
    send(64, 64, 0, 0, 32, 0, 64, 0, "rec0");
    send(0, 64, 0, 0, 32, 0, 32, 0, "rec1");
    send(0, 64, 0, 0, 32, 0, 16, 0, "rec2");
    send(0, 64, 0, 0, 32, 0, 8, 0, "rec3");

    // Overflow: 127*100/64 = 198, 127*-128/64 = -254
    pulse_clr();
`ifdef IIR_SAT_EN
    send(100, 127, 0, 0, 0, 0, 127, 1, "ovf_pos");
    send(-128, 127, 0, 0, 0, 0, -128, 1, "ovf_neg");
`else
    send(100, 127, 0, 0, 0, 0, -58, 0, "ovf_pos");
    send(-128, 127, 0, 0, 0, 0, 2, 0, "ovf_neg");
`endif

    // Reset mid-MAC overrides clr and in_valid
    xn = 8'(25); b0 = 8'(64); b1 = '0; b2 = '0; a1 = '0; a2 = '0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0; clr = 1'b1; in_valid = 1'b1;
    tick();
    check("mid_rst_yn", int'(yn), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0;
    tick();
    send(25, 64, 0, 0, 0, 0, 25, 0, "post_rst");

    // in_valid held high: one acceptance per 7 edges
    pulse_clr();
    xn = 8'(5); b0 = 8'(64); b1 = '0; b2 = '0; a1 = '0; a2 = '0;
    in_valid = 1'b1;
    n_acc = 0;
    n_out = 0;
    for (int k = 0; k < 21; k++) begin
      if (in_ready) n_acc++;
      tick();
      if (out_valid) n_out++;
    end
    in_valid = 1'b0;
    check("hold_accepts", n_acc, 3);
    check("hold_outputs", n_out, 3);
    check("hold_yn", int'(yn), 5);

    // clr during tap 2 aborts the sample and flushes history
    xn = 8'(77); b0 = 8'(64);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_out = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid) n_out++;
    end
    check("abort_no_out", n_out, 0);
    check("abort_yn_held", int'(yn), 5);
    check("abort_ready", int'(in_ready), 1);
    send(9, 0, 64, 0, 0, 0, 0, 0, "abort_hist");

    // clr beats in_valid in IDLE
    xn = 8'(40); b0 = 8'(64);
    in_valid = 1'b1;
    clr = 1'b1;
    tick();
    in_valid = 1'b0;
    clr = 1'b0;
    check("clr_wins_ready", int'(in_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
